// File: rtl/counter_reload_ctrl.sv
// Reload sequencer for the 8-bit loadable up counter: watches count against limit-1 and
// issues a one-cycle load from a reload FIFO. Optional macro: COUNTER_RELOAD_REPEAT_EN.
module counter_reload_ctrl #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     clr,
    input  logic [WIDTH-1:0]         count,
    input  logic [WIDTH-1:0]         limit,
    input  logic                     wr_valid,
    input  logic [WIDTH-1:0]         wr_data,
    output logic                     wr_ready,
    output logic                     load,
    output logic [WIDTH-1:0]         data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LOAD = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             load_q, load_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             underflow_q, underflow_d;
    logic [LW-1:0]    level_q, level_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic             full, empty, match, push, pop;
    logic [WIDTH-1:0] limit_m1;

    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        full        = (level_q == LW'(DEPTH));
        empty       = (level_q == '0);
        limit_m1    = limit - WIDTH'(1);
        match       = (count == limit_m1);
        push        = wr_valid && !full && !clr;
        pop         = 1'b0;
        state_d     = state_q;
        load_d      = 1'b0;
        data_d      = data_q;
        underflow_d = underflow_q;

        case (state_q)
            IDLE: begin
                if (enable) state_d = RUN;
            end
            RUN: begin
                if (match && !clr && !empty) begin
                    state_d = LOAD;
                    load_d  = 1'b1;
                    data_d  = mem_q[rd_ptr_q];
                    pop     = 1'b1;
                end else if (match && !clr) begin
                    underflow_d = 1'b1;
`ifdef COUNTER_RELOAD_REPEAT_EN
                    // data_q only ever changes on a load, so it already holds the last value loaded.
                    state_d = LOAD;
                    load_d  = 1'b1;
`else
                    if (!enable) state_d = IDLE;
`endif
                end else if (!enable) begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                state_d = enable ? RUN : IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (clr) underflow_d = 1'b0;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            load_q      <= 1'b0;
            data_q      <= '0;
            underflow_q <= 1'b0;
            level_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            load_q      <= load_d;
            data_q      <= data_d;
            underflow_q <= underflow_d;
            level_q     <= level_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    // NOTE: storage is not reset; level and pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data;
    end

    assign wr_ready  = !full;
    assign load      = load_q;
    assign data      = data_q;
    assign level     = level_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_counter_reload_ctrl.sv
// Bench for counter_reload_ctrl: vector table plus reload-value scoreboard and an async
// reset sequence. Expectations follow COUNTER_RELOAD_REPEAT_EN when it is defined.
module tb_counter_reload_ctrl;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;
`ifdef COUNTER_RELOAD_REPEAT_EN
    localparam logic REPEAT = 1'b1;
`else
    localparam logic REPEAT = 1'b0;
`endif

    logic             clk      = 1'b0;
    logic             rst      = 1'b0;
    logic             enable   = 1'b0;
    logic             clr      = 1'b0;
    logic [WIDTH-1:0] count    = '0;
    logic [WIDTH-1:0] limit    = '0;
    logic             wr_valid = 1'b0;
    logic [WIDTH-1:0] wr_data  = '0;
    logic             wr_ready;
    logic             load;
    logic [WIDTH-1:0] data;
    logic [LW-1:0]    level;
    logic             underflow;

    always #5 clk = ~clk;

    counter_reload_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .clr       (clr),
        .count     (count),
        .limit     (limit),
        .wr_valid  (wr_valid),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .load      (load),
        .data      (data),
        .level     (level),
        .underflow (underflow)
    );

    typedef struct {
        logic             en;
        logic [WIDTH-1:0] cnt;
        logic [WIDTH-1:0] lim;
        logic             wv;
        logic [WIDTH-1:0] wd;
        logic             clr;
        logic             e_load;
        logic [LW-1:0]    e_level;
        logic             e_ready;
        logic             e_uf;
    } vec_t;

    vec_t             vecs[$];
    logic [WIDTH-1:0] sb_q[$];
    logic [WIDTH-1:0] last_loaded = '0;
    int               n_checks    = 0;
    int               n_fail      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic en, input logic [WIDTH-1:0] cnt,
                                input logic [WIDTH-1:0] lim, input logic wv,
                                input logic [WIDTH-1:0] wd, input logic cl,
                                input logic el, input int elv, input logic er, input logic eu);
        vec_t v;
        v.en = en; v.cnt = cnt; v.lim = lim; v.wv = wv; v.wd = wd; v.clr = cl;
        v.e_load = el; v.e_level = LW'(elv); v.e_ready = er; v.e_uf = eu;
        return v;
    endfunction

    // Drive one cycle of stimulus, keep the reload queue in step, then compare after the edge.
    task automatic apply(input vec_t v, input string tag);
        int               pre_size;
        logic             accept;
        logic [WIDTH-1:0] exp_d;
        enable   = v.en;
        count    = v.cnt;
        limit    = v.lim;
        wr_valid = v.wv;
        wr_data  = v.wd;
        clr      = v.clr;
        pre_size = sb_q.size();
        accept   = v.wv && (pre_size < DEPTH) && !v.clr;
        @(posedge clk);
        #1;
        if (v.clr) sb_q.delete();
        if (accept) sb_q.push_back(v.wd);
        check({tag, ".load"},      32'(load),      32'(v.e_load));
        check({tag, ".level"},     32'(level),     32'(v.e_level));
        check({tag, ".wr_ready"},  32'(wr_ready),  32'(v.e_ready));
        check({tag, ".underflow"}, 32'(underflow), 32'(v.e_uf));
        if (load) begin
            // A value pushed in the pop cycle of an empty FIFO must not be the one loaded.
            if (pre_size == 0) exp_d = last_loaded;
            else               exp_d = sb_q.pop_front();
            check({tag, ".data"}, 32'(data), 32'(exp_d));
            last_loaded = exp_d;
        end
    endtask

    initial begin
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.load",      32'(load),      32'(1'b0));
        check("rst.data",      32'(data),      32'(8'h00));
        check("rst.level",     32'(level),     32'(0));
        check("rst.wr_ready",  32'(wr_ready),  32'(1'b1));
        check("rst.underflow", 32'(underflow), 32'(1'b0));
        rst = 1'b1;

        //                  en cnt    lim    wv wd     clr load    lvl rdy uf
        vecs.push_back(mk(0, 8'h00, 8'h20, 0, 8'h00, 0, 0,      0, 1, 0));
        vecs.push_back(mk(0, 8'h01, 8'h20, 0, 8'h00, 0, 0,      0, 1, 0));
        vecs.push_back(mk(0, 8'h02, 8'h20, 0, 8'h00, 0, 0,      0, 1, 0));
        vecs.push_back(mk(0, 8'h03, 8'h20, 1, 8'h10, 0, 0,      1, 1, 0));
        vecs.push_back(mk(1, 8'h1E, 8'h20, 0, 8'h00, 0, 0,      1, 1, 0));
        vecs.push_back(mk(1, 8'h1E, 8'h20, 0, 8'h00, 0, 0,      1, 1, 0));
        vecs.push_back(mk(1, 8'h1F, 8'h20, 0, 8'h00, 0, 1,      0, 1, 0));
        vecs.push_back(mk(1, 8'h20, 8'h20, 0, 8'h00, 0, 0,      0, 1, 0));
        vecs.push_back(mk(1, 8'h10, 8'h20, 0, 8'h00, 0, 0,      0, 1, 0));
        vecs.push_back(mk(1, 8'h03, 8'h05, 0, 8'h00, 0, 0,      0, 1, 0));
        vecs.push_back(mk(1, 8'h04, 8'h05, 0, 8'h00, 0, REPEAT, 0, 1, 1));
        vecs.push_back(mk(1, 8'h05, 8'h05, 0, 8'h00, 0, 0,      0, 1, 1));
        vecs.push_back(mk(1, 8'h00, 8'h05, 1, 8'h33, 1, 0,      0, 1, 0));
        vecs.push_back(mk(0, 8'h00, 8'h05, 0, 8'h00, 0, 0,      0, 1, 0));
        vecs.push_back(mk(0, 8'h00, 8'h05, 1, 8'hA1, 0, 0,      1, 1, 0));
        vecs.push_back(mk(0, 8'h00, 8'h05, 1, 8'hA2, 0, 0,      2, 1, 0));
        vecs.push_back(mk(0, 8'h00, 8'h05, 1, 8'hA3, 0, 0,      3, 1, 0));
        vecs.push_back(mk(0, 8'h00, 8'h05, 1, 8'hA4, 0, 0,      4, 0, 0));
        vecs.push_back(mk(0, 8'h00, 8'h05, 1, 8'hA5, 0, 0,      4, 0, 0));
        vecs.push_back(mk(1, 8'h00, 8'h50, 1, 8'hA5, 0, 0,      4, 0, 0));
        vecs.push_back(mk(1, 8'h4F, 8'h50, 1, 8'hA5, 0, 1,      3, 1, 0));
        vecs.push_back(mk(1, 8'h50, 8'h50, 1, 8'hA5, 0, 0,      4, 0, 0));
        vecs.push_back(mk(1, 8'hA1, 8'h50, 0, 8'h00, 0, 0,      4, 0, 0));
        vecs.push_back(mk(1, 8'hFF, 8'h00, 0, 8'h00, 0, 1,      3, 1, 0));
        vecs.push_back(mk(1, 8'hFF, 8'h00, 0, 8'h00, 0, 0,      3, 1, 0));
        vecs.push_back(mk(1, 8'hFF, 8'h00, 0, 8'h00, 0, 1,      2, 1, 0));
        vecs.push_back(mk(0, 8'h00, 8'h00, 0, 8'h00, 0, 0,      2, 1, 0));
        vecs.push_back(mk(0, 8'hFF, 8'h00, 0, 8'h00, 0, 0,      2, 1, 0));
        vecs.push_back(mk(1, 8'hFF, 8'h00, 0, 8'h00, 0, 0,      2, 1, 0));
        vecs.push_back(mk(1, 8'hFF, 8'h00, 0, 8'h00, 0, 1,      1, 1, 0));
        vecs.push_back(mk(1, 8'h00, 8'h00, 0, 8'h00, 0, 0,      1, 1, 0));
        vecs.push_back(mk(1, 8'hFF, 8'h00, 1, 8'hB1, 0, 1,      1, 1, 0));
        vecs.push_back(mk(1, 8'h00, 8'h00, 0, 8'h00, 0, 0,      1, 1, 0));
        vecs.push_back(mk(1, 8'hFF, 8'h00, 0, 8'h00, 0, 1,      0, 1, 0));
        vecs.push_back(mk(1, 8'h00, 8'h00, 0, 8'h00, 0, 0,      0, 1, 0));
        vecs.push_back(mk(1, 8'hFF, 8'h00, 1, 8'hC1, 0, REPEAT, 1, 1, 1));
        vecs.push_back(mk(1, 8'h00, 8'h00, 0, 8'h00, 0, 0,      1, 1, 1));
        vecs.push_back(mk(0, 8'h00, 8'h00, 0, 8'h00, 1, 0,      0, 1, 0));
        vecs.push_back(mk(0, 8'h00, 8'h00, 1, 8'h42, 0, 0,      1, 1, 0));
        vecs.push_back(mk(0, 8'h00, 8'h00, 1, 8'h43, 0, 0,      2, 1, 0));
        vecs.push_back(mk(1, 8'h00, 8'h00, 0, 8'h00, 0, 0,      2, 1, 0));
        vecs.push_back(mk(1, 8'hFF, 8'h00, 0, 8'h00, 0, 1,      1, 1, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("v%0d", i));
        end

        // Asynchronous reset while the load strobe is high, well before the next clock edge.
        #2;
        rst      = 1'b0;
        enable   = 1'b0;
        wr_valid = 1'b0;
        count    = 8'h00;
        #1;
        check("arst.load",      32'(load),      32'(1'b0));
        check("arst.level",     32'(level),     32'(0));
        check("arst.wr_ready",  32'(wr_ready),  32'(1'b1));
        check("arst.data",      32'(data),      32'(8'h00));
        check("arst.underflow", 32'(underflow), 32'(1'b0));
        @(negedge clk);
        rst = 1'b1;
        sb_q.delete();
        last_loaded = '0;

        // FIFO contents are gone: an empty-FIFO match now underflows (or repeats 0x00).
        apply(mk(0, 8'h00, 8'h00, 0, 8'h00, 0, 0,      0, 1, 0), "post0");
        apply(mk(1, 8'h00, 8'h00, 0, 8'h00, 0, 0,      0, 1, 0), "post1");
        apply(mk(1, 8'hFF, 8'h00, 0, 8'h00, 0, REPEAT, 0, 1, 1), "post2");
        apply(mk(0, 8'h00, 8'h00, 0, 8'h00, 1, 0,      0, 1, 0), "post3");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/counter_reload_ctrl.md
# counter_reload_ctrl

Reload sequencer that drives the `load`/`data` inputs of the team's 8-bit loadable up counter. It watches the counter's `count` output against a programmable terminal value. At each terminal crossing it issues a single-cycle `load` carrying the next reload value, taken from a small FIFO that software or an upstream block fills over a valid/ready handshake. Placement: directly upstream of the counter, in a closed loop with it.

## Interface
Parameters:
- WIDTH, 8, width of count, limit and reload values
- DEPTH, 4, reload FIFO entries (power of two, ≥2)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- enable  in  1  1 = monitor count and issue reloads
- clr  in  1  synchronous FIFO flush; also clears `underflow`
- count  in  WIDTH  current counter value
- limit  in  WIDTH  terminal value; the counter is reloaded instead of advancing past it
- wr_valid  in  1  reload value offered
- wr_data  in  WIDTH  reload value
- wr_ready  out  1  FIFO can accept; equals !full
- load  out  1  registered load strobe to counter
- data  out  WIDTH  registered reload value to counter
- level  out  $clog2(DEPTH)+1  FIFO occupancy
- underflow  out  1  sticky: a terminal crossing found the FIFO empty

## Operation
- Reset values: load=0, data=0, level=0, underflow=0, wr_ready=1, FSM=IDLE, FIFO pointers=0.
- Push: a value is written when wr_valid && wr_ready at the clock edge. There is no bypass; a full FIFO deasserts wr_ready even if a pop occurs in the same cycle.
- Pre-terminal match: `count == limit - 1`, computed modulo 2^WIDTH (limit=0 matches count=all-ones).
- FSM states:
  - IDLE: load=0. Moves to RUN when enable=1.
  - RUN: on match with FIFO non-empty, move to LOAD. At that edge `data` gets the FIFO head and the head is popped. With enable=0 and no match, return to IDLE.
  - LOAD: load=1 for exactly one cycle. Next state is RUN if enable=1, otherwise IDLE. Compare is ignored in this cycle.
- Match in RUN with FIFO empty: no load, the counter wraps naturally, and `underflow` is set. Exception: RELOAD_REPEAT_EN (see Configuration).
- Simultaneous push and pop: both take effect and `level` is unchanged. A push in the pop cycle into an empty FIFO does not satisfy that pop.
- clr in the same cycle as a push or pop: clr wins, giving level=0 and the push discarded. A LOAD already in progress still completes with its captured `data`.
- enable falling in LOAD: the load pulse still completes.
- Reset mid-operation: all outputs return to reset values immediately (asynchronous); FIFO contents are lost.

## Timing
- Match seen in cycle N (count=limit-1) gives load=1 in cycle N+1, while count=limit. At the N+2 edge the counter takes `data`. The counter never presents limit+1.
- If the reloaded value equals limit-1, the match re-fires in the following cycle. Back-to-back reloads are allowed, one per two cycles.
- wr_ready and level update the cycle after push or pop.
- underflow sets at the edge after the failed match and holds until clr or rst.

## Configuration
- `COUNTER_RELOAD_REPEAT_EN` defined: a register holds the last value loaded, reset to 0. On a match with the FIFO empty, the FSM still enters LOAD and reloads that value. `underflow` is still set.
- Not defined: behaviour is as in Operation, with no load on empty. The last-value register is not present.

## Test plan
- Reset and idle: rst=0 then 1 with enable=0 and count sweeping → load=0, data=0, wr_ready=1, level=0 throughout.
- Single reload: push 0x10, limit=0x20, enable=1, count stepping up from 0x1E → load=1 in the cycle count=0x20, data=0x10, level goes 1→0, underflow=0.
- Underflow: FIFO empty, limit=0x05, count reaches 0x04 → no load, underflow=1. With the macro, and last value 0x10: load=1, data=0x10, underflow=1.
- Full FIFO: push 5 values with DEPTH=4 → first 4 accepted, level=4, wr_ready=0, 5th held. One reload pops 0x1st value, then the 5th is accepted.
- Wrap compare: limit=0x00, count=0xFF → load=1 next cycle with the FIFO head.
- Async reset mid-LOAD: assert rst while load=1 → load=0, level=0 immediately, without waiting for a clock edge.
